reg_bank16: RTL

- 16 x 16-bit general register bank. Sits directly upstream of the 16:1 operand multiplexor: REGS slices drive its IN0..IN15.
- R15 doubles as the program counter. PC_OUT feeds the 14-bit 2:1 address multiplexor.
- Provides a write-back port, an increment/decrement port for pointer registers, PC load/step, and a one-deep shadow copy for interrupt save/restore.

---
 rtl/reg_bank16_pkg.sv | 48 ++++
 rtl/reg_bank16_cell.sv | 53 +++++
 rtl/reg_bank16.sv | 91 +++++++++
 3 files changed

// File: rtl/reg_bank16_pkg.sv
// Shared constants and per-register operation select for the 16 x 16-bit register bank.
// The decode function fixes the per-register source priority in one place.
package reg_bank16_pkg;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned PC_WIDTH = 14;
    localparam int unsigned PC_REG   = 15;
    localparam int unsigned NUM_REGS = 16;
    localparam logic [PC_WIDTH-1:0] RESET_PC = 14'h0000;

    typedef enum logic [2:0] {
        OpNone,
        OpRestore,
        OpWe,
        OpInc,
        OpPcLoad,
        OpPcStep
    } op_sel_e;

    // Highest priority first: accepted restore, write-back, inc/dec, PC load, PC step.
    function automatic op_sel_e decode_op(
        input logic [3:0] idx,
        input logic       is_pc,
        input logic       restore_ok,
        input logic       we,
        input logic [3:0] waddr,
        input logic       inc_en,
        input logic [3:0] inc_addr,
        input logic       pc_load,
        input logic       pc_step
    );
        op_sel_e op;
        op = OpNone;
        if (restore_ok) begin
            op = OpRestore;
        end else if (we && (waddr == idx)) begin
            op = OpWe;
        end else if (inc_en && (inc_addr == idx)) begin
            op = OpInc;
        end else if (is_pc && pc_load) begin
            op = OpPcLoad;
        end else if (is_pc && pc_step) begin
            op = OpPcStep;
        end
        return op;
    endfunction

endpackage

// File: rtl/reg_bank16_cell.sv
// One bank register plus its one-deep shadow copy.
// The shadow always captures the pre-update value so save/restore can swap atomically.
module reg_bank16_cell
    import reg_bank16_pkg::*;
#(
    parameter int unsigned          Width    = WIDTH,
    parameter int unsigned          PcWidth  = PC_WIDTH,
    parameter logic [Width-1:0]     ResetVal = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  op_sel_e            op,
    input  logic               save,
    input  logic [Width-1:0]   wdata,
    input  logic               inc_dec,
    input  logic [PcWidth-1:0] pc_in,
    output logic [Width-1:0]   value
);

    logic [Width-1:0]   value_q;
    logic [Width-1:0]   value_d;
    logic [Width-1:0]   shadow_q;
    logic [PcWidth-1:0] pc_next;

    assign pc_next = value_q[PcWidth-1:0] + PcWidth'(1);

    always_comb begin
        value_d = value_q;
        case (op)
            OpRestore: value_d = shadow_q;
            OpWe:      value_d = wdata;
            OpInc:     value_d = inc_dec ? (value_q - Width'(1)) : (value_q + Width'(1));
            OpPcLoad:  value_d = Width'(pc_in);
            OpPcStep:  value_d = Width'(pc_next);
            default:   value_d = value_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q  <= ResetVal;
            shadow_q <= '0;
        end else begin
            value_q <= value_d;
            if (save) begin
                shadow_q <= value_q;
            end
        end
    end

    assign value = value_q;

endmodule

// File: rtl/reg_bank16.sv
// 16 x 16-bit register bank with R15 as program counter and a one-deep shadow context.
// Top level decodes per-register operations and tracks shadow validity and restore errors.
module reg_bank16
    import reg_bank16_pkg::*;
#(
    parameter int unsigned            W_BITS  = WIDTH,
    parameter int unsigned            PC_BITS = PC_WIDTH,
    parameter int unsigned            PC_IDX  = PC_REG,
    parameter logic [PC_BITS-1:0]     PC_RST  = RESET_PC
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   WE,
    input  logic [3:0]             WADDR,
    input  logic [W_BITS-1:0]      WDATA,
    input  logic                   INC_EN,
    input  logic [3:0]             INC_ADDR,
    input  logic                   INC_DEC,
    input  logic                   PC_LOAD,
    input  logic [PC_BITS-1:0]     PC_IN,
    input  logic                   PC_STEP,
    input  logic                   SAVE,
    input  logic                   RESTORE,
    output logic [16*W_BITS-1:0]   REGS,
    output logic [PC_BITS-1:0]     PC_OUT,
    output logic                   SHADOW_VALID,
    output logic                   ERR
);

    logic shadow_valid_q;
    logic shadow_valid_d;
    logic err_q;
    logic err_d;
    logic restore_ok;

    assign restore_ok = RESTORE && shadow_valid_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        localparam logic            IsPc = (i == PC_IDX);
        localparam logic [W_BITS-1:0] RstVal = IsPc ? W_BITS'(PC_RST) : '0;

        op_sel_e          op;
        logic [W_BITS-1:0] value;

        assign op = decode_op(4'(i), IsPc, restore_ok, WE, WADDR, INC_EN, INC_ADDR,
                              PC_LOAD, PC_STEP);

        reg_bank16_cell #(
            .Width    (W_BITS),
            .PcWidth  (PC_BITS),
            .ResetVal (RstVal)
        ) u_cell (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .op      (op),
            .save    (SAVE),
            .wdata   (WDATA),
            .inc_dec (INC_DEC),
            .pc_in   (PC_IN),
            .value   (value)
        );

        assign REGS[i*W_BITS +: W_BITS] = value;
    end

    // SAVE wins over a clearing restore, which keeps a swap's shadow valid.
    always_comb begin
        shadow_valid_d = shadow_valid_q;
        if (SAVE) begin
            shadow_valid_d = 1'b1;
        end else if (restore_ok) begin
            shadow_valid_d = 1'b0;
        end
        err_d = RESTORE && !shadow_valid_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            shadow_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
            err_q          <= err_d;
        end
    end

    assign PC_OUT       = REGS[PC_IDX*W_BITS +: PC_BITS];
    assign SHADOW_VALID = shadow_valid_q;
    assign ERR          = err_q;

endmodule
